cpu_run_controller: RTL and testbench

- Execution sequencer in front of the 8-bit, 24-bit-instruction CPU core.
- Holds the core in reset after power-up and gates its clock-enable.
- Accepts RUN/HALT/STEP/SET_BP commands over a valid/ready port.
- Stops the core on a PC breakpoint or a HALT opcode, and counts executed cycles for the debug/host side.

---
 rtl/cpu_run_controller.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_run_controller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: execution sequencer in front of the 8-bit, 24-bit-instruction CPU core.
//   Holds the core in reset after power-up and gates its clock-enable.
//   Accepts RUN/HALT/STEP/SET_BP commands over a valid/ready port.
//   Stops the core on a PC breakpoint or a HALT opcode.
//   Counts executed cycles for the debug/host side.
// Optional feature: define RUN_LIMIT_EN to bound each RUN to RUN_LIMIT executed cycles.
// Ports:
//   CLK, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command port (0=RUN,1=HALT,2=STEP,3=SET_BP)
//   pc, opcode                          : current core PC and opcode of the instruction at pc
//   core_en (combinational), core_reset : core advance enable / active-high core reset
//   halted, done, stop_reason           : status (done is a one-cycle pulse on stop)
//   cycle_count                         : saturating count of cycles with core_en=1
module cpu_run_controller #(
  parameter int unsigned PC_W         = 8,
  parameter int unsigned CNT_W        = 16,
  parameter logic [3:0]  HALT_OPCODE  = 4'hF,
  parameter int unsigned RESET_CYCLES = 2
`ifdef RUN_LIMIT_EN
  ,
  parameter int unsigned RUN_LIMIT    = 1000
`endif
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [PC_W:0]    cmd_data,
  input  logic [PC_W-1:0]  pc,
  input  logic [3:0]       opcode,
  output logic             core_en,
  output logic             core_reset,
  output logic             halted,
  output logic             done,
  output logic [2:0]       stop_reason,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned     RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  localparam logic [1:0] OP_RUN    = 2'd0;
  localparam logic [1:0] OP_HALT   = 2'd1;
  localparam logic [1:0] OP_STEP   = 2'd2;
  localparam logic [1:0] OP_SET_BP = 2'd3;

  localparam logic [2:0] SR_HALT_CMD = 3'd0;
  localparam logic [2:0] SR_BP       = 3'd1;
  localparam logic [2:0] SR_HALT_OP  = 3'd2;
  localparam logic [2:0] SR_STEP     = 3'd3;
`ifdef RUN_LIMIT_EN
  localparam logic [2:0] SR_LIMIT    = 3'd4;
`endif

  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_RUN, ST_STEP} state_t;

  state_t          r_state,   w_state_nxt;
  logic [RC_W-1:0] r_rst_cnt, w_rst_cnt_nxt;
  logic            r_resume,  w_resume_nxt;
  logic            r_bp_en,   w_bp_en_nxt;
  logic [PC_W-1:0] r_bp_addr, w_bp_addr_nxt;
  logic            r_done,    w_done_nxt;
  logic [2:0]      r_reason,  w_reason_nxt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic            w_core_en;
  logic            w_fire;
  logic            w_halt_op;
  logic            w_bp_hit;
`ifdef RUN_LIMIT_EN
  logic [CNT_W-1:0] r_run_cnt, w_run_cnt_nxt;
  logic             w_limit;
`endif

  // State-decoded status outputs
  assign cmd_ready   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign core_reset  = (r_state == ST_RST);
  assign halted      = (r_state == ST_IDLE);
  assign core_en     = w_core_en;
  assign done        = r_done;
  assign stop_reason = r_reason;
  assign cycle_count = r_cycle_cnt;

  assign w_fire    = cmd_valid & cmd_ready;
  assign w_halt_op = (opcode == HALT_OPCODE);
  // resume masks the breakpoint for the first RUN cycle so a restart at the bp PC makes progress
  assign w_bp_hit  = r_bp_en & (pc == r_bp_addr) & ~r_resume;
`ifdef RUN_LIMIT_EN
  assign w_limit   = (r_run_cnt >= CNT_W'(RUN_LIMIT));
`endif

  // Next-state, core enable and stop bookkeeping
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_resume_nxt  = r_resume;
    w_bp_en_nxt   = r_bp_en;
    w_bp_addr_nxt = r_bp_addr;
    w_done_nxt    = 1'b0;
    w_reason_nxt  = r_reason;
    w_core_en     = 1'b0;

    if (w_fire && (cmd_op == OP_SET_BP)) begin
      w_bp_en_nxt   = cmd_data[PC_W];
      w_bp_addr_nxt = cmd_data[PC_W-1:0];
    end

    case (r_state)
      ST_RST: begin
        if (r_rst_cnt == RC_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_rst_cnt_nxt = RC_W'(r_rst_cnt + 1'b1);
        end
      end
      ST_IDLE: begin
        if (w_fire && (cmd_op == OP_RUN)) begin
          w_state_nxt  = ST_RUN;
          w_resume_nxt = 1'b1;
        end else if (w_fire && (cmd_op == OP_STEP)) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        w_resume_nxt = 1'b0;
        if (w_halt_op) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_reason_nxt = SR_HALT_OP;
        end else if (w_bp_hit) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_reason_nxt = SR_BP;
`ifdef RUN_LIMIT_EN
        end else if (w_limit) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_reason_nxt = SR_LIMIT;
`endif
        end else begin
          // HALT command still lets the current instruction retire
          w_core_en = 1'b1;
          if (w_fire && (cmd_op == OP_HALT)) begin
            w_state_nxt  = ST_IDLE;
            w_done_nxt   = 1'b1;
            w_reason_nxt = SR_HALT_CMD;
          end
        end
      end
      ST_STEP: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
        if (w_halt_op) begin
          w_reason_nxt = SR_HALT_OP;
        end else begin
          w_core_en    = 1'b1;
          w_reason_nxt = SR_STEP;
        end
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

`ifdef RUN_LIMIT_EN
  // Per-RUN executed-cycle counter
  always_comb begin
    w_run_cnt_nxt = r_run_cnt;
    if ((r_state == ST_IDLE) && w_fire && (cmd_op == OP_RUN)) begin
      w_run_cnt_nxt = '0;
    end else if ((r_state == ST_RUN) && w_core_en) begin
      w_run_cnt_nxt = CNT_W'(r_run_cnt + 1'b1);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_run_cnt <= '0;
    end else begin
      r_run_cnt <= w_run_cnt_nxt;
    end
  end
`endif

  // State and status registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RST;
      r_rst_cnt   <= '0;
      r_resume    <= 1'b0;
      r_bp_en     <= 1'b0;
      r_bp_addr   <= '0;
      r_done      <= 1'b0;
      r_reason    <= SR_HALT_CMD;
      r_cycle_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_resume  <= w_resume_nxt;
      r_bp_en   <= w_bp_en_nxt;
      r_bp_addr <= w_bp_addr_nxt;
      r_done    <= w_done_nxt;
      r_reason  <= w_reason_nxt;
      if (w_core_en && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= CNT_W'(r_cycle_cnt + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed testbench for cpu_run_controller; the core PC is advanced by the bench
// whenever core_en was high at a clock edge.
module tb_cpu_run_controller;

  logic        CLK = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_data;
  logic [7:0]  pc;
  logic [3:0]  opcode;
  logic        core_en;
  logic        core_reset;
  logic        halted;
  logic        done;
  logic [2:0]  stop_reason;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

`ifdef RUN_LIMIT_EN
  cpu_run_controller #(.RUN_LIMIT(10)) dut (
`else
  cpu_run_controller dut (
`endif
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc), .opcode(opcode),
    .core_en(core_en), .core_reset(core_reset), .halted(halted), .done(done),
    .stop_reason(stop_reason), .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one command in IDLE/RUN; held for one clock
  task automatic send(input logic [1:0] op, input logic [8:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready op=%0d: got %b want 1", op, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; pc = '0; opcode = 4'h0;
    #2 reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({core_reset, core_en, cmd_ready, halted, done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got rst/en/rdy/hlt/done=%b want 10000",
               {core_reset, core_en, cmd_ready, halted, done});
    end
    checks++;
    if (cycle_count !== 16'd0 || stop_reason !== 3'd0) begin
      errors++;
      $display("FAIL reset_counters: got cnt=%0d sr=%0d want 0 0", cycle_count, stop_reason);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (core_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold1: got core_reset=%b want 1", core_reset);
    end
    tick();
    checks++;
    if ({core_reset, halted, cmd_ready, done} !== 4'b0110 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: got rst/hlt/rdy/done=%b cnt=%0d want 0110 0",
               {core_reset, halted, cmd_ready, done}, cycle_count);
    end
  endtask

  task automatic test_breakpoint();
    send(2'd3, 9'h105);
    pc = 8'd0;
    send(2'd0, 9'h000);
    for (int i = 0; i < 5; i++) begin
      pc = 8'(i);
      #1;
      checks++;
      if (core_en !== 1'b1) begin
        errors++;
        $display("FAIL bp_run_en pc=%0d: got %b want 1", i, core_en);
      end
      tick();
    end
    exp_cnt += 5;
    pc = 8'd5;
    #1;
    checks++;
    if (core_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_kill: got core_en=%b want 0", core_en);
    end
    tick();
    checks++;
    if ({done, halted} !== 2'b11 || stop_reason !== 3'd1 || cycle_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL bp_stop: got done/hlt=%b sr=%0d cnt=%0d want 11 1 %0d",
               {done, halted}, stop_reason, cycle_count, exp_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL bp_done_pulse: got done=%b want 0", done);
    end
  endtask

  // Restart at the breakpoint PC, then stop with a HALT command
  task automatic test_resume_halt_cmd();
    send(2'd0, 9'h000);
    #1;
    checks++;
    if (core_en !== 1'b1) begin
      errors++;
      $display("FAIL resume_at_bp: got core_en=%b want 1", core_en);
    end
    tick();
    pc = 8'd6;
    #1;
    checks++;
    if (core_en !== 1'b1) begin
      errors++;
      $display("FAIL resume_past_bp: got core_en=%b want 1", core_en);
    end
    tick();
    pc = 8'd7;
    cmd_valid = 1'b1; cmd_op = 2'd1;
    #1;
    checks++;
    if ({core_en, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL halt_cmd_cycle: got en/rdy=%b want 11", {core_en, cmd_ready});
    end
    tick();
    cmd_valid = 1'b0;
    exp_cnt += 3;
    checks++;
    if ({done, halted} !== 2'b11 || stop_reason !== 3'd0 || cycle_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL halt_cmd_stop: got done/hlt=%b sr=%0d cnt=%0d want 11 0 %0d",
               {done, halted}, stop_reason, cycle_count, exp_cnt);
    end
  endtask

  // HALT opcode at PC 3 coinciding with a breakpoint at 3: opcode wins
  task automatic test_halt_opcode();
    send(2'd3, 9'h103);
    pc = 8'd0;
    send(2'd0, 9'h000);
    for (int i = 0; i < 3; i++) begin
      pc = 8'(i);
      #1;
      checks++;
      if (core_en !== 1'b1) begin
        errors++;
        $display("FAIL hop_run_en pc=%0d: got %b want 1", i, core_en);
      end
      tick();
    end
    exp_cnt += 3;
    pc = 8'd3; opcode = 4'hF;
    #1;
    checks++;
    if (core_en !== 1'b0) begin
      errors++;
      $display("FAIL hop_kill: got core_en=%b want 0", core_en);
    end
    tick();
    opcode = 4'h0;
    checks++;
    if ({done, halted} !== 2'b11 || stop_reason !== 3'd2 || cycle_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL hop_stop: got done/hlt=%b sr=%0d cnt=%0d want 11 2 %0d",
               {done, halted}, stop_reason, cycle_count, exp_cnt);
    end
  endtask

  // Steps start on the enabled breakpoint PC; STEP ignores it
  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      send(2'd2, 9'h000);
      #1;
      checks++;
      if ({core_en, cmd_ready, halted} !== 3'b100) begin
        errors++;
        $display("FAIL step_cycle %0d: got en/rdy/hlt=%b want 100", i, {core_en, cmd_ready, halted});
      end
      tick();
      exp_cnt += 1;
      checks++;
      if ({done, halted} !== 2'b11 || stop_reason !== 3'd3 || cycle_count !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL step_done %0d: got done/hlt=%b sr=%0d cnt=%0d want 11 3 %0d",
                 i, {done, halted}, stop_reason, cycle_count, exp_cnt);
      end
      pc = pc + 8'd1;
    end
    opcode = 4'hF;
    send(2'd2, 9'h000);
    #1;
    checks++;
    if (core_en !== 1'b0) begin
      errors++;
      $display("FAIL step_hop_en: got core_en=%b want 0", core_en);
    end
    tick();
    opcode = 4'h0;
    checks++;
    if (done !== 1'b1 || stop_reason !== 3'd2 || cycle_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL step_hop_stop: got done=%b sr=%0d cnt=%0d want 1 2 %0d",
               done, stop_reason, cycle_count, exp_cnt);
    end
    send(2'd1, 9'h000);
    checks++;
    if ({halted, done} !== 2'b10 || stop_reason !== 3'd2) begin
      errors++;
      $display("FAIL idle_halt_noop: got hlt/done=%b sr=%0d want 10 2", {halted, done}, stop_reason);
    end
  endtask

  task automatic test_run_limit();
    send(2'd3, 9'h000);
    pc = 8'd20;
    send(2'd0, 9'h000);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cmd_valid = 1'b1; cmd_op = 2'd0;
      end
      #1;
      checks++;
      if (core_en !== 1'b1) begin
        errors++;
        $display("FAIL limit_run_en cyc=%0d: got %b want 1", i, core_en);
      end
      tick();
      cmd_valid = 1'b0;
      pc = pc + 8'd1;
    end
    exp_cnt += 10;
`ifdef RUN_LIMIT_EN
    #1;
    checks++;
    if (core_en !== 1'b0) begin
      errors++;
      $display("FAIL limit_kill: got core_en=%b want 0", core_en);
    end
    tick();
    checks++;
    if ({done, halted} !== 2'b11 || stop_reason !== 3'd4 || cycle_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL limit_stop: got done/hlt=%b sr=%0d cnt=%0d want 11 4 %0d",
               {done, halted}, stop_reason, cycle_count, exp_cnt);
    end
`else
    cmd_valid = 1'b1; cmd_op = 2'd1;
    #1;
    checks++;
    if (core_en !== 1'b1) begin
      errors++;
      $display("FAIL nolimit_run_en: got core_en=%b want 1", core_en);
    end
    tick();
    cmd_valid = 1'b0;
    exp_cnt += 1;
    checks++;
    if ({done, halted} !== 2'b11 || stop_reason !== 3'd0 || cycle_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL nolimit_stop: got done/hlt=%b sr=%0d cnt=%0d want 11 0 %0d",
               {done, halted}, stop_reason, cycle_count, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    send(2'd0, 9'h000);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({core_reset, core_en, halted, done} !== 4'b1000 || cycle_count !== 16'd0 || stop_reason !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset: got rst/en/hlt/done=%b cnt=%0d sr=%0d want 1000 0 0",
               {core_reset, core_en, halted, done}, cycle_count, stop_reason);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_done cyc=%0d: got done=%b want 0", i, done);
      end
    end
    checks++;
    if ({core_reset, halted} !== 2'b01) begin
      errors++;
      $display("FAIL midrun_recover: got rst/hlt=%b want 01", {core_reset, halted});
    end
  endtask

  initial begin
    test_reset();
    test_breakpoint();
    test_resume_halt_cmd();
    test_halt_opcode();
    test_step();
    test_run_limit();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
